// File: rtl/clk_delay_tap_ctrl.sv
// clk_delay_tap_ctrl: sequences DIR/MOVE/LOAD pulses for a divided-clock delay line and tracks the tap position.
module clk_delay_tap_ctrl #(
  parameter int CNT_W     = 8,
  parameter int TAP_MAX   = 255,
  parameter int INIT_TAP  = 1,
  parameter int SETUP_CYC = 2,
  parameter int MOVE_GAP  = 3
) (
  input  logic             SCLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [CNT_W-1:0] CMD_STEPS,
  output logic             DONE,
  output logic [CNT_W-1:0] TAP_POS,
  output logic             ERR_OOR,
  input  logic             ERR_CLR,
  output logic             DELAY_LINE_DIR,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_LOAD,
  input  logic             DELAY_LINE_OUT_OF_RANGE
);
  typedef enum logic [2:0] {IDLE, LOADP, SETUP, MOVEP, GAP, FIN} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [CNT_W-1:0] remaining;
  logic oor_s1, oor_s2;
  logic at_limit;
  assign at_limit = DELAY_LINE_DIR ? (TAP_POS == CNT_W'(TAP_MAX)) : (TAP_POS == '0);
  assign CMD_READY = (state == IDLE) && !RESET;
  // ERR_CLR is applied first so that a set later in the same cycle wins
  always_ff @(posedge SCLK or posedge RESET) begin
    if (RESET) begin
      state           <= IDLE;
      cnt             <= '0;
      remaining       <= '0;
      oor_s1          <= 1'b0;
      oor_s2          <= 1'b0;
      DONE            <= 1'b0;
      TAP_POS         <= CNT_W'(INIT_TAP);
      ERR_OOR         <= 1'b0;
      DELAY_LINE_DIR  <= 1'b0;
      DELAY_LINE_MOVE <= 1'b0;
      DELAY_LINE_LOAD <= 1'b0;
    end else begin
      oor_s1          <= DELAY_LINE_OUT_OF_RANGE;
      oor_s2          <= oor_s1;
      DONE            <= 1'b0;
      DELAY_LINE_MOVE <= 1'b0;
      DELAY_LINE_LOAD <= 1'b0;
      if (ERR_CLR) ERR_OOR <= 1'b0;
      case (state)
        IDLE: if (CMD_VALID) begin
          remaining <= CMD_STEPS;
          if (CMD_OP == 2'b00) begin
            state           <= LOADP;
            DELAY_LINE_LOAD <= 1'b1;
          end else if (CMD_OP != 2'b11 && CMD_STEPS != '0) begin
            state          <= SETUP;
            cnt            <= 4'(SETUP_CYC - 1);
            DELAY_LINE_DIR <= (CMD_OP == 2'b01);
          end else begin
            state <= FIN;
            DONE  <= 1'b1;
          end
        end
        LOADP: begin
          TAP_POS   <= CNT_W'(INIT_TAP);
          remaining <= '0;
          cnt       <= 4'(MOVE_GAP - 1);
          state     <= GAP;
        end
        SETUP: if (cnt != '0) cnt <= cnt - 4'd1;
          else if (at_limit) begin
            ERR_OOR <= 1'b1;
            state   <= FIN;
            DONE    <= 1'b1;
          end else begin
            state           <= MOVEP;
            DELAY_LINE_MOVE <= 1'b1;
          end
        MOVEP: begin
          TAP_POS   <= DELAY_LINE_DIR ? TAP_POS + CNT_W'(1) : TAP_POS - CNT_W'(1);
          remaining <= remaining - CNT_W'(1);
          cnt       <= 4'(MOVE_GAP - 1);
          state     <= GAP;
        end
        GAP: if (cnt != '0) cnt <= cnt - 4'd1;
          else if (oor_s2 || (remaining != '0 && at_limit)) begin
            ERR_OOR <= 1'b1;
            state   <= FIN;
            DONE    <= 1'b1;
          end else if (remaining == '0) begin
            state <= FIN;
            DONE  <= 1'b1;
          end else begin
            state           <= MOVEP;
            DELAY_LINE_MOVE <= 1'b1;
          end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
